// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - ALU reservation station with dual-CDB snoop and registered issue
// Holds dispatched ops until both operands are present, then issues the lowest ready entry.
module rs_alu #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 5,
  parameter int OP_W  = 7
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [31:0]      in_vj,
  input  logic             in_qj_busy,
  input  logic [ROB_W-1:0] in_qj,
  input  logic [31:0]      in_vk,
  input  logic             in_qk_busy,
  input  logic [ROB_W-1:0] in_qk,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [ROB_W-1:0] in_rob,
  output logic             full,
  input  logic             cdb0_valid,
  input  logic [ROB_W-1:0] cdb0_tag,
  input  logic [31:0]      cdb0_val,
  input  logic             cdb1_valid,
  input  logic [ROB_W-1:0] cdb1_tag,
  input  logic [31:0]      cdb1_val,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_vi,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_imm,
  output logic [ROB_W-1:0] alu_rd,
  output logic [31:0]      alu_pc
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] qj_busy_q, qj_busy_d;
  logic [DEPTH-1:0] qk_busy_q, qk_busy_d;
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [OP_W-1:0]  op_d  [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vj_d  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic [31:0]      vk_d  [DEPTH];
  logic [31:0]      imm_q [DEPTH];
  logic [31:0]      imm_d [DEPTH];
  logic [31:0]      pc_q  [DEPTH];
  logic [31:0]      pc_d  [DEPTH];
  logic [ROB_W-1:0] qj_q  [DEPTH];
  logic [ROB_W-1:0] qj_d  [DEPTH];
  logic [ROB_W-1:0] qk_q  [DEPTH];
  logic [ROB_W-1:0] qk_d  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [ROB_W-1:0] rob_d [DEPTH];

  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [31:0]      alu_vi_q, alu_vi_d;
  logic [31:0]      alu_vj_q, alu_vj_d;
  logic [31:0]      alu_imm_q, alu_imm_d;
  logic [ROB_W-1:0] alu_rd_q, alu_rd_d;
  logic [31:0]      alu_pc_q, alu_pc_d;

  logic [IDX_W-1:0] free_idx, issue_idx;
  logic             issue_vld, accept;
  logic             fj_hit, fk_hit;
  logic [31:0]      fj_val, fk_val;

  assign full   = &busy_q;
  assign accept = in_valid && (in_op != '0) && !full;

  // Descending scan so the last match written is the lowest index.
  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    issue_vld = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i]) begin
        issue_idx = IDX_W'(i);
        issue_vld = 1'b1;
      end
    end
  end

  always_comb begin
    fj_hit = 1'b0;
    fj_val = in_vj;
    fk_hit = 1'b0;
    fk_val = in_vk;
    if (in_qj_busy) begin
      if (cdb0_valid && cdb0_tag == in_qj) begin
        fj_hit = 1'b1;
        fj_val = cdb0_val;
      end else if (cdb1_valid && cdb1_tag == in_qj) begin
        fj_hit = 1'b1;
        fj_val = cdb1_val;
      end
    end
    if (in_qk_busy) begin
      if (cdb0_valid && cdb0_tag == in_qk) begin
        fk_hit = 1'b1;
        fk_val = cdb0_val;
      end else if (cdb1_valid && cdb1_tag == in_qk) begin
        fk_hit = 1'b1;
        fk_val = cdb1_val;
      end
    end
  end

  always_comb begin
    busy_d    = busy_q;
    qj_busy_d = qj_busy_q;
    qk_busy_d = qk_busy_q;
    op_d      = op_q;
    vj_d      = vj_q;
    vk_d      = vk_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    rob_d     = rob_q;
    alu_op_d  = alu_op_q;
    alu_vi_d  = alu_vi_q;
    alu_vj_d  = alu_vj_q;
    alu_imm_d = alu_imm_q;
    alu_rd_d  = alu_rd_q;
    alu_pc_d  = alu_pc_q;
    if (clear_in) begin
      busy_d   = '0;
      alu_op_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && qj_busy_q[i]) begin
          if (cdb0_valid && cdb0_tag == qj_q[i]) begin
            vj_d[i]      = cdb0_val;
            qj_busy_d[i] = 1'b0;
          end else if (cdb1_valid && cdb1_tag == qj_q[i]) begin
            vj_d[i]      = cdb1_val;
            qj_busy_d[i] = 1'b0;
          end
        end
        if (busy_q[i] && qk_busy_q[i]) begin
          if (cdb0_valid && cdb0_tag == qk_q[i]) begin
            vk_d[i]      = cdb0_val;
            qk_busy_d[i] = 1'b0;
          end else if (cdb1_valid && cdb1_tag == qk_q[i]) begin
            vk_d[i]      = cdb1_val;
            qk_busy_d[i] = 1'b0;
          end
        end
      end
      if (issue_vld) begin
        alu_op_d          = op_q[issue_idx];
        alu_vi_d          = vj_q[issue_idx];
        alu_vj_d          = vk_q[issue_idx];
        alu_imm_d         = imm_q[issue_idx];
        alu_rd_d          = rob_q[issue_idx];
        alu_pc_d          = pc_q[issue_idx];
        busy_d[issue_idx] = 1'b0;
      end else begin
        alu_op_d = '0;
      end
      // free_idx is never the issuing entry, so both writes coexist.
      if (accept) begin
        busy_d[free_idx]    = 1'b1;
        op_d[free_idx]      = in_op;
        vj_d[free_idx]      = fj_val;
        qj_busy_d[free_idx] = in_qj_busy && !fj_hit;
        qj_d[free_idx]      = in_qj;
        vk_d[free_idx]      = fk_val;
        qk_busy_d[free_idx] = in_qk_busy && !fk_hit;
        qk_d[free_idx]      = in_qk;
        imm_d[free_idx]     = in_imm;
        pc_d[free_idx]      = in_pc;
        rob_d[free_idx]     = in_rob;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q    <= '0;
      alu_op_q  <= '0;
      alu_vi_q  <= '0;
      alu_vj_q  <= '0;
      alu_imm_q <= '0;
      alu_rd_q  <= '0;
      alu_pc_q  <= '0;
    end else if (rdy_in) begin
      busy_q    <= busy_d;
      qj_busy_q <= qj_busy_d;
      qk_busy_q <= qk_busy_d;
      op_q      <= op_d;
      vj_q      <= vj_d;
      vk_q      <= vk_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      qj_q      <= qj_d;
      qk_q      <= qk_d;
      rob_q     <= rob_d;
      alu_op_q  <= alu_op_d;
      alu_vi_q  <= alu_vi_d;
      alu_vj_q  <= alu_vj_d;
      alu_imm_q <= alu_imm_d;
      alu_rd_q  <= alu_rd_d;
      alu_pc_q  <= alu_pc_d;
    end
  end

  assign alu_op  = alu_op_q;
  assign alu_vi  = alu_vi_q;
  assign alu_vj  = alu_vj_q;
  assign alu_imm = alu_imm_q;
  assign alu_rd  = alu_rd_q;
  assign alu_pc  = alu_pc_q;

endmodule

// File: tb/tb_rs_alu.sv
// tb/tb_rs_alu.sv - directed and randomized checks of rs_alu against a station model
// The model tracks entries as records and issues the lowest-index ready one each cycle.
module tb_rs_alu;
  localparam int DEPTH = 8;
  localparam int ROB_W = 5;
  localparam int OP_W  = 7;
  localparam logic [6:0] OP_ADD = 7'd1;
  localparam logic [6:0] OP_SUB = 7'd2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in, in_valid;
  logic [6:0]  in_op;
  logic [31:0] in_vj, in_vk, in_imm, in_pc;
  logic        in_qj_busy, in_qk_busy;
  logic [4:0]  in_qj, in_qk, in_rob;
  logic        full;
  logic        cdb0_valid, cdb1_valid;
  logic [4:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_val, cdb1_val;
  logic [6:0]  alu_op;
  logic [31:0] alu_vi, alu_vj, alu_imm, alu_pc;
  logic [4:0]  alu_rd;

  always #5 clk_in = ~clk_in;

  rs_alu #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .in_valid(in_valid), .in_op(in_op), .in_vj(in_vj), .in_qj_busy(in_qj_busy),
    .in_qj(in_qj), .in_vk(in_vk), .in_qk_busy(in_qk_busy), .in_qk(in_qk),
    .in_imm(in_imm), .in_pc(in_pc), .in_rob(in_rob), .full(full),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
    .alu_op(alu_op), .alu_vi(alu_vi), .alu_vj(alu_vj), .alu_imm(alu_imm),
    .alu_rd(alu_rd), .alu_pc(alu_pc)
  );

  typedef struct {
    bit          busy;
    logic [6:0]  op;
    logic [31:0] vj;
    bit          qjb;
    logic [4:0]  qj;
    logic [31:0] vk;
    bit          qkb;
    logic [4:0]  qk;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rob;
  } ent_t;

  ent_t        m [DEPTH];
  logic [6:0]  e_op;
  logic [31:0] e_vi, e_vj, e_imm, e_pc;
  logic [4:0]  e_rd;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int occupancy();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].busy) n++;
    return n;
  endfunction

  // {hit, value}: the ALU bus takes precedence over the LSB bus.
  function automatic logic [32:0] bus_value(input logic [4:0] tag);
    if (cdb0_valid && cdb0_tag == tag) return {1'b1, cdb0_val};
    if (cdb1_valid && cdb1_tag == tag) return {1'b1, cdb1_val};
    return 33'd0;
  endfunction

  task automatic model_step();
    ent_t        nxt [DEPTH];
    int          sel, fr;
    logic [32:0] h;
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
      e_op = '0; e_vi = '0; e_vj = '0; e_imm = '0; e_rd = '0; e_pc = '0;
      return;
    end
    if (!rdy_in) return;
    if (clear_in) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
      e_op = '0;
      return;
    end
    nxt = m;
    sel = -1;
    fr  = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy && m[i].qjb) begin
        h = bus_value(m[i].qj);
        if (h[32]) begin nxt[i].vj = h[31:0]; nxt[i].qjb = 0; end
      end
      if (m[i].busy && m[i].qkb) begin
        h = bus_value(m[i].qk);
        if (h[32]) begin nxt[i].vk = h[31:0]; nxt[i].qkb = 0; end
      end
    end
    if (sel >= 0) begin
      e_op = m[sel].op; e_vi = m[sel].vj; e_vj = m[sel].vk;
      e_imm = m[sel].imm; e_rd = m[sel].rob; e_pc = m[sel].pc;
      nxt[sel].busy = 0;
    end else begin
      e_op = '0;
    end
    if (in_valid && in_op != 0 && fr >= 0) begin
      nxt[fr].busy = 1;
      nxt[fr].op = in_op; nxt[fr].imm = in_imm; nxt[fr].pc = in_pc; nxt[fr].rob = in_rob;
      nxt[fr].qj = in_qj; nxt[fr].qk = in_qk;
      nxt[fr].vj = in_vj; nxt[fr].qjb = in_qj_busy;
      nxt[fr].vk = in_vk; nxt[fr].qkb = in_qk_busy;
      if (in_qj_busy) begin
        h = bus_value(in_qj);
        if (h[32]) begin nxt[fr].vj = h[31:0]; nxt[fr].qjb = 0; end
      end
      if (in_qk_busy) begin
        h = bus_value(in_qk);
        if (h[32]) begin nxt[fr].vk = h[31:0]; nxt[fr].qkb = 0; end
      end
    end
    m = nxt;
  endtask

  task automatic check_model();
    chk("op",   32'(alu_op), 32'(e_op));
    chk("vi",   alu_vi, e_vi);
    chk("vj",   alu_vj, e_vj);
    chk("imm",  alu_imm, e_imm);
    chk("rd",   32'(alu_rd), 32'(e_rd));
    chk("pc",   alu_pc, e_pc);
    chk("full", 32'(full), 32'(occupancy() == DEPTH));
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    check_model();
  endtask

  task automatic idle();
    in_valid = 0; in_op = '0; in_vj = '0; in_qj_busy = 0; in_qj = '0;
    in_vk = '0; in_qk_busy = 0; in_qk = '0; in_imm = '0; in_pc = '0; in_rob = '0;
    cdb0_valid = 0; cdb0_tag = '0; cdb0_val = '0;
    cdb1_valid = 0; cdb1_tag = '0; cdb1_val = '0;
    clear_in = 0;
  endtask

  task automatic dispatch(input logic [6:0] op, input logic [31:0] vj, input logic qjb,
                          input logic [4:0] qj, input logic [31:0] vk, input logic qkb,
                          input logic [4:0] qk, input logic [4:0] rob);
    in_valid = 1; in_op = op; in_vj = vj; in_qj_busy = qjb; in_qj = qj;
    in_vk = vk; in_qk_busy = qkb; in_qk = qk; in_rob = rob;
    in_imm = 32'h1000 + 32'(rob);
    in_pc  = 32'h8000_0000 + 32'(rob) * 4;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1;
    idle();
    cycle(); cycle();
    rst_in = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_op", 32'(alu_op), 32'd0);
    chk("rst_vi", alu_vi, 32'd0);
    chk("rst_pc", alu_pc, 32'd0);
    chk("rst_rd", 32'(alu_rd), 32'd0);
    chk("rst_full", 32'(full), 32'd0);

    // Both operands ready: issue one edge after accept, one-cycle strobe.
    dispatch(OP_ADD, 32'd5, 0, 5'd0, 32'd7, 0, 5'd0, 5'd3);
    cycle();
    idle();
    cycle();
    chk("add_op", 32'(alu_op), 32'(OP_ADD));
    chk("add_vi", alu_vi, 32'd5);
    chk("add_vj", alu_vj, 32'd7);
    chk("add_rd", 32'(alu_rd), 32'd3);
    cycle();
    chk("add_strobe", 32'(alu_op), 32'd0);

    // Wake-up through cdb1.
    dispatch(OP_SUB, 32'd0, 1, 5'd9, 32'd1, 0, 5'd0, 5'd4);
    cycle();
    idle();
    cycle(); cycle();
    chk("sub_wait", 32'(alu_op), 32'd0);
    cdb1_valid = 1; cdb1_tag = 5'd9; cdb1_val = 32'h100;
    cycle();
    chk("sub_wake_edge", 32'(alu_op), 32'd0);
    idle();
    cycle();
    chk("sub_op", 32'(alu_op), 32'(OP_SUB));
    chk("sub_vi", alu_vi, 32'h100);
    chk("sub_vj", alu_vj, 32'd1);

    // Same-cycle forwarding on accept.
    dispatch(OP_ADD, 32'hdead, 1, 5'd2, 32'd3, 0, 5'd0, 5'd5);
    cdb0_valid = 1; cdb0_tag = 5'd2; cdb0_val = 32'd42;
    cycle();
    idle();
    cycle();
    chk("fwd_op", 32'(alu_op), 32'(OP_ADD));
    chk("fwd_vi", alu_vi, 32'd42);

    // Fill, overflow, then drain in index order.
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(OP_ADD, 32'd0, 1, 5'd1, 32'(i), 0, 5'd0, 5'(i));
      cycle();
    end
    chk("fill_full", 32'(full), 32'd1);
    dispatch(OP_SUB, 32'd9, 0, 5'd0, 32'd9, 0, 5'd0, 5'd20);
    cycle();
    chk("overflow_full", 32'(full), 32'd1);
    idle();
    cdb0_valid = 1; cdb0_tag = 5'd1; cdb0_val = 32'd77;
    cycle();
    chk("drain_wake", 32'(alu_op), 32'd0);
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("drain_op", 32'(alu_op), 32'(OP_ADD));
      chk("drain_rd", 32'(alu_rd), 32'(i));
      chk("drain_vi", alu_vi, 32'd77);
      if (i == 0) chk("drain_full", 32'(full), 32'd0);
    end
    cycle();
    chk("overflow_lost", 32'(alu_op), 32'd0);

    // Flush with competing accept and broadcast.
    for (int i = 0; i < 4; i++) begin
      dispatch(OP_ADD, 32'd0, 1, 5'd6, 32'd0, 0, 5'd0, 5'(i + 8));
      cycle();
    end
    dispatch(OP_SUB, 32'd1, 0, 5'd0, 32'd1, 0, 5'd0, 5'd12);
    clear_in = 1;
    cdb0_valid = 1; cdb0_tag = 5'd6; cdb0_val = 32'd5;
    cycle();
    chk("clr_full", 32'(full), 32'd0);
    chk("clr_op", 32'(alu_op), 32'd0);
    idle();
    cdb0_valid = 1; cdb0_tag = 5'd6; cdb0_val = 32'd5;
    cycle();
    idle();
    cycle();
    chk("clr_empty0", 32'(alu_op), 32'd0);
    cycle();
    chk("clr_empty1", 32'(alu_op), 32'd0);

    // Stall freezes a live strobe and defers the next issue.
    dispatch(OP_ADD, 32'd1, 0, 5'd0, 32'd2, 0, 5'd0, 5'd10);
    cycle();
    dispatch(OP_SUB, 32'd3, 0, 5'd0, 32'd4, 0, 5'd0, 5'd11);
    cycle();
    idle();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_op", 32'(alu_op), 32'(OP_ADD));
      chk("stall_rd", 32'(alu_rd), 32'd10);
    end
    rdy_in = 1;
    cycle();
    chk("resume_op", 32'(alu_op), 32'(OP_SUB));
    chk("resume_rd", 32'(alu_rd), 32'd11);
    cycle();
    chk("resume_idle", 32'(alu_op), 32'd0);

    // Randomized traffic with small tag space to force frequent hits.
    for (int n = 0; n < 3000; n++) begin
      rst_in   = ($urandom_range(0, 199) == 0);
      rdy_in   = ($urandom_range(0, 9) != 0);
      clear_in = ($urandom_range(0, 29) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_op    = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      in_vj    = $urandom; in_vk = $urandom; in_imm = $urandom; in_pc = $urandom;
      in_qj_busy = $urandom_range(0, 1) == 1;
      in_qk_busy = $urandom_range(0, 2) == 0;
      in_qj    = 5'($urandom_range(0, 7));
      in_qk    = 5'($urandom_range(0, 7));
      in_rob   = 5'($urandom);
      cdb0_valid = $urandom_range(0, 9) < 4;
      cdb1_valid = $urandom_range(0, 9) < 4;
      cdb0_tag = 5'($urandom_range(0, 7));
      cdb1_tag = 5'($urandom_range(0, 7));
      if (cdb1_tag == cdb0_tag) cdb1_tag = cdb0_tag ^ 5'd1;
      cdb0_val = $urandom; cdb1_val = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
